// File: rtl/regfile_result_checker.sv
// Shadows a core's register writebacks and byte stores during a run, then scores them against a preloaded table.
// Table checks take one cycle per entry (NUM_CHECKS cycles after RUN ends); inputs have no backpressure.
module regfile_result_checker #(
   parameter int XLEN           = 32,
   parameter int NUM_CHECKS     = 8,
   parameter int MEM_BYTES      = 16,
   parameter int CYCLE_LIMIT    = 30,
   parameter int PASS_THRESHOLD = 5,
   localparam int CW = $clog2(NUM_CHECKS + 1),
   localparam int IW = $clog2(NUM_CHECKS),
   localparam int MW = $clog2(MEM_BYTES)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  cfg_we,
   input  logic [IW-1:0]         cfg_idx,
   input  logic                  cfg_en,
   input  logic                  cfg_kind,
   input  logic [7:0]            cfg_addr,
   input  logic [XLEN-1:0]       cfg_value,
   input  logic                  start,
   input  logic                  halt,
   input  logic                  wb_valid,
   input  logic [4:0]            wb_rd,
   input  logic [XLEN-1:0]       wb_data,
   input  logic                  st_valid,
   input  logic [MW-1:0]         st_addr,
   input  logic [7:0]            st_data,
   output logic                  busy,
   output logic                  done,
   output logic                  timeout,
   output logic [CW-1:0]         pass_count,
   output logic [NUM_CHECKS-1:0] fail_mask,
   output logic                  verdict,
   output logic [15:0]           cycle_count
);

   typedef enum logic [1:0] {IDLE, RUN, CHECK, DONE} state_t;

   state_t                state_q, state_d;
   logic [NUM_CHECKS-1:0] tbl_en_q, tbl_en_d;
   logic [NUM_CHECKS-1:0] tbl_kind_q, tbl_kind_d;
   logic [7:0]            tbl_addr_q [NUM_CHECKS];
   logic [7:0]            tbl_addr_d [NUM_CHECKS];
   logic [XLEN-1:0]       tbl_val_q  [NUM_CHECKS];
   logic [XLEN-1:0]       tbl_val_d  [NUM_CHECKS];
   logic [XLEN-1:0]       regs_q     [32];
   logic [XLEN-1:0]       regs_d     [32];
   logic [7:0]            mem_q      [MEM_BYTES];
   logic [7:0]            mem_d      [MEM_BYTES];
   logic [15:0]           cycle_count_q, cycle_count_d;
   logic [IW-1:0]         chk_idx_q, chk_idx_d;
   logic [CW-1:0]         pass_count_q, pass_count_d;
   logic [NUM_CHECKS-1:0] fail_mask_q, fail_mask_d;
   logic                  timeout_q, timeout_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  verdict_q, verdict_d;

   logic [7:0]            chk_addr;
   logic [XLEN-1:0]       chk_exp;
   logic [XLEN-1:0]       chk_reg_val;
   logic [7:0]            chk_mem_val;
   logic                  chk_match;
   logic                  unused_addr_bits;

   // x0 is architecturally zero, so its shadow slot is never read.
   always_comb begin
      chk_addr    = tbl_addr_q[chk_idx_q];
      chk_exp     = tbl_val_q[chk_idx_q];
      chk_reg_val = (chk_addr[4:0] == 5'd0) ? '0 : regs_q[chk_addr[4:0]];
      chk_mem_val = mem_q[chk_addr[MW-1:0]];
      chk_match   = tbl_kind_q[chk_idx_q] ? (chk_mem_val == chk_exp[7:0])
                                          : (chk_reg_val == chk_exp);
   end

   assign unused_addr_bits = ^chk_addr;

   always_comb begin
      state_d       = state_q;
      tbl_en_d      = tbl_en_q;
      tbl_kind_d    = tbl_kind_q;
      tbl_addr_d    = tbl_addr_q;
      tbl_val_d     = tbl_val_q;
      regs_d        = regs_q;
      mem_d         = mem_q;
      cycle_count_d = cycle_count_q;
      chk_idx_d     = chk_idx_q;
      pass_count_d  = pass_count_q;
      fail_mask_d   = fail_mask_q;
      timeout_d     = timeout_q;

      if (cfg_we && (state_q == IDLE || state_q == DONE) && (int'(cfg_idx) < NUM_CHECKS)) begin
         tbl_en_d[cfg_idx]   = cfg_en;
         tbl_kind_d[cfg_idx] = cfg_kind;
         tbl_addr_d[cfg_idx] = cfg_addr;
         tbl_val_d[cfg_idx]  = cfg_value;
      end

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               for (int i = 0; i < 32; i++) regs_d[i] = '0;
               for (int i = 0; i < MEM_BYTES; i++) mem_d[i] = '0;
               cycle_count_d = '0;
               chk_idx_d     = '0;
               pass_count_d  = '0;
               fail_mask_d   = '0;
               timeout_d     = 1'b0;
               state_d       = RUN;
            end
         end
         RUN: begin
            if (cycle_count_q != 16'hFFFF) cycle_count_d = cycle_count_q + 16'd1;
            if (wb_valid && (wb_rd != 5'd0)) regs_d[wb_rd] = wb_data;
            if (st_valid) mem_d[st_addr] = st_data;
            // halt wins over the cycle limit when both land on the same cycle
            if (halt) begin
               state_d   = CHECK;
               chk_idx_d = '0;
               timeout_d = 1'b0;
            end else if (cycle_count_q == 16'(CYCLE_LIMIT - 1)) begin
               state_d   = CHECK;
               chk_idx_d = '0;
               timeout_d = 1'b1;
            end
         end
         CHECK: begin
            if (tbl_en_q[chk_idx_q]) begin
               if (chk_match) pass_count_d = pass_count_q + CW'(1);
               else           fail_mask_d[chk_idx_q] = 1'b1;
            end
            if (chk_idx_q == IW'(NUM_CHECKS - 1)) state_d = DONE;
            else                                  chk_idx_d = chk_idx_q + IW'(1);
         end
         default: state_d = IDLE;
      endcase

      busy_d    = (state_d == RUN) || (state_d == CHECK);
      done_d    = (state_d == DONE);
      verdict_d = (state_d == DONE) && (pass_count_d >= CW'(PASS_THRESHOLD));
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= IDLE;
         tbl_en_q      <= '0;
         tbl_kind_q    <= '0;
         for (int i = 0; i < NUM_CHECKS; i++) begin
            tbl_addr_q[i] <= '0;
            tbl_val_q[i]  <= '0;
         end
         for (int i = 0; i < 32; i++) regs_q[i] <= '0;
         for (int i = 0; i < MEM_BYTES; i++) mem_q[i] <= '0;
         cycle_count_q <= '0;
         chk_idx_q     <= '0;
         pass_count_q  <= '0;
         fail_mask_q   <= '0;
         timeout_q     <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         verdict_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         tbl_en_q      <= tbl_en_d;
         tbl_kind_q    <= tbl_kind_d;
         tbl_addr_q    <= tbl_addr_d;
         tbl_val_q     <= tbl_val_d;
         regs_q        <= regs_d;
         mem_q         <= mem_d;
         cycle_count_q <= cycle_count_d;
         chk_idx_q     <= chk_idx_d;
         pass_count_q  <= pass_count_d;
         fail_mask_q   <= fail_mask_d;
         timeout_q     <= timeout_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         verdict_q     <= verdict_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign timeout     = timeout_q;
   assign pass_count  = pass_count_q;
   assign fail_mask   = fail_mask_q;
   assign verdict     = verdict_q;
   assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_regfile_result_checker.sv
// Directed bench for regfile_result_checker: table of full runs plus hand sequences for x0, cfg-in-RUN and reset abort.
module tb_regfile_result_checker;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        cfg_we;
   logic [2:0]  cfg_idx;
   logic        cfg_en;
   logic        cfg_kind;
   logic [7:0]  cfg_addr;
   logic [31:0] cfg_value;
   logic        start;
   logic        halt;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        st_valid;
   logic [3:0]  st_addr;
   logic [7:0]  st_data;
   logic        busy;
   logic        done;
   logic        timeout;
   logic [3:0]  pass_count;
   logic [7:0]  fail_mask;
   logic        verdict;
   logic [15:0] cycle_count;

   int n_vec = 0;
   int n_bad = 0;

   regfile_result_checker dut (
      .clk(clk), .reset_n(reset_n),
      .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en), .cfg_kind(cfg_kind),
      .cfg_addr(cfg_addr), .cfg_value(cfg_value),
      .start(start), .halt(halt),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
      .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
      .busy(busy), .done(done), .timeout(timeout), .pass_count(pass_count),
      .fail_mask(fail_mask), .verdict(verdict), .cycle_count(cycle_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] r1, r2, r3, r4, r5, r6;
      logic [7:0]  m0;
      int          halt_cyc;
      int          e_pass;
      logic [7:0]  e_mask;
      logic        e_verdict;
      logic        e_timeout;
      int          e_cyc;
   } vec_t;

   vec_t vecs[5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cfg(input int idx, input bit en, input bit kind, input int addr, input logic [31:0] val);
      @(negedge clk);
      cfg_we = 1'b1; cfg_idx = 3'(idx); cfg_en = en; cfg_kind = kind;
      cfg_addr = 8'(addr); cfg_value = val;
      @(negedge clk);
      cfg_we = 1'b0;
   endtask

   task automatic load_table();
      cfg(0, 1, 0, 1, 32'd7);
      cfg(1, 1, 0, 2, 32'd7);
      cfg(2, 1, 0, 3, 32'd0);
      cfg(3, 1, 0, 4, 32'd7);
      cfg(4, 1, 0, 5, 32'd1);
      cfg(5, 1, 0, 6, 32'd1);
      cfg(6, 1, 1, 0, 32'd7);
      cfg(7, 0, 0, 0, 32'd0);
   endtask

   task automatic clear_drive();
      wb_valid = 1'b0; st_valid = 1'b0; halt = 1'b0; cfg_we = 1'b0;
   endtask

   // One full run: writes x1..x6 on cycles 1..6, mem[0] alongside x6, a write to x0 on cycle 8.
   task automatic run_vec(input string tag, input vec_t v, input bit writes, input bit cfg_mid);
      int last;
      last = (v.halt_cyc > 0) ? v.halt_cyc : 30;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk({tag, "_busy_run"}, 32'(busy), 32'd1);
      chk({tag, "_verdict_run"}, 32'(verdict), 32'd0);
      for (int k = 1; k <= last; k++) begin
         clear_drive();
         if (writes) begin
            wb_valid = 1'b1;
            case (k)
               1: begin wb_rd = 5'd1; wb_data = v.r1; end
               2: begin wb_rd = 5'd2; wb_data = v.r2; end
               3: begin wb_rd = 5'd3; wb_data = v.r3; end
               4: begin wb_rd = 5'd4; wb_data = v.r4; end
               5: begin wb_rd = 5'd5; wb_data = v.r5; end
               6: begin wb_rd = 5'd6; wb_data = v.r6;
                        st_valid = 1'b1; st_addr = 4'd0; st_data = v.m0; end
               8: begin wb_rd = 5'd0; wb_data = 32'd5; end
               default: wb_valid = 1'b0;
            endcase
         end
         if (cfg_mid && k == 9) begin
            cfg_we = 1'b1; cfg_idx = 3'd0; cfg_en = 1'b1; cfg_kind = 1'b0;
            cfg_addr = 8'd1; cfg_value = 32'd99;
         end
         if (k == v.halt_cyc) halt = 1'b1;
         @(negedge clk);
      end
      clear_drive();
      for (int w = 0; w < 40 && !done; w++) @(negedge clk);
      chk({tag, "_done"}, 32'(done), 32'd1);
      chk({tag, "_busy_done"}, 32'(busy), 32'd0);
      chk({tag, "_pass"}, 32'(pass_count), 32'(v.e_pass));
      chk({tag, "_mask"}, 32'(fail_mask), 32'(v.e_mask));
      chk({tag, "_verdict"}, 32'(verdict), 32'(v.e_verdict));
      chk({tag, "_timeout"}, 32'(timeout), 32'(v.e_timeout));
      chk({tag, "_cycles"}, 32'(cycle_count), 32'(v.e_cyc));
      @(negedge clk);
      chk({tag, "_done_held"}, 32'(done), 32'd1);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_timeout"}, 32'(timeout), 32'd0);
      chk({tag, "_pass"}, 32'(pass_count), 32'd0);
      chk({tag, "_mask"}, 32'(fail_mask), 32'd0);
      chk({tag, "_verdict"}, 32'(verdict), 32'd0);
      chk({tag, "_cycles"}, 32'(cycle_count), 32'd0);
   endtask

   initial begin
      vec_t hv;

      //            r1  r2  r3  r4  r5  r6  m0  halt pass mask   vrd  tmo  cyc
      vecs[0] = '{32'd7, 32'd7, 32'd0, 32'd7, 32'd1, 32'd1, 8'd7, 12, 7, 8'h00, 1'b1, 1'b0, 12};
      vecs[1] = '{32'd7, 32'd7, 32'd0, 32'd6, 32'd1, 32'd1, 8'd7,  0, 6, 8'h08, 1'b1, 1'b1, 30};
      vecs[2] = '{32'd8, 32'd9, 32'd0, 32'd7, 32'd1, 32'd1, 8'd3, 10, 4, 8'h43, 1'b0, 1'b0, 10};
      vecs[3] = '{32'd7, 32'd7, 32'd0, 32'd7, 32'd1, 32'd1, 8'd7,  3, 3, 8'h78, 1'b0, 1'b0,  3};
      vecs[4] = '{32'd7, 32'd7, 32'd0, 32'd7, 32'd1, 32'd1, 8'd7, 30, 7, 8'h00, 1'b1, 1'b0, 30};

      reset_n = 1'b0; start = 1'b0; cfg_idx = '0; cfg_en = 1'b0; cfg_kind = 1'b0;
      cfg_addr = '0; cfg_value = '0; wb_rd = '0; wb_data = '0; st_addr = '0; st_data = '0;
      clear_drive();
      repeat (2) @(negedge clk);
      chk_all_zero("reset");
      reset_n = 1'b1;

      load_table();
      for (int i = 0; i < 5; i++) run_vec($sformatf("v%0d", i), vecs[i], 1'b1, 1'b0);

      // x0 entry expects 0 despite a write of 5; entry 0 overwrite attempted during RUN
      cfg(7, 1, 0, 0, 32'd0);
      hv = vecs[0];
      hv.e_pass = 8;
      run_vec("x0_cfgrun", hv, 1'b1, 1'b1);

      // reset during CHECK: aborted run had x1/x2 matching, which must not leak into the next run
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wb_valid = 1'b1; wb_rd = 5'd1; wb_data = 32'd7;
      @(negedge clk);
      wb_rd = 5'd2; halt = 1'b1;
      @(negedge clk);
      clear_drive();
      repeat (2) @(negedge clk);
      chk("abort_busy_pre", 32'(busy), 32'd1);
      chk("abort_pass_pre", 32'(pass_count), 32'd2);
      #2 reset_n = 1'b0;
      #1 chk_all_zero("abort");
      @(negedge clk);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("abort_no_done", 32'(done), 32'd0);
      chk("abort_idle_busy", 32'(busy), 32'd0);

      load_table();
      hv = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 8'd0, 4, 1, 8'h7B, 1'b0, 1'b0, 4};
      run_vec("clean", hv, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
